// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared keyboard definitions: Set-2 prefix/status bytes, decoder states and the event record.
// The optional Pause-sequence folding is enabled by defining PAUSE_SEQ_EN.
package ps2_scancode_decoder_pkg;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_REL    = 8'hF0;
   localparam logic [7:0] SC_PAUSE  = 8'hE1;
   localparam logic [7:0] SC_BAT    = 8'hAA;
   localparam logic [7:0] SC_ACK    = 8'hFA;
   localparam logic [7:0] SC_ECHO   = 8'hEE;
   localparam logic [7:0] SC_RESEND = 8'hFE;
   localparam logic [7:0] SC_ERR0   = 8'h00;
   localparam logic [7:0] SC_ERR1   = 8'hFF;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRead   = 2'd1,
      StDecode = 2'd2
   } dec_state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       rel;
   } kbd_event_t;

   // Bytes that never become an event on their own (prefixes, pause lead-in, status).
   function automatic logic is_control_byte(input logic [7:0] b);
      return (b == SC_EXT)  || (b == SC_REL)    || (b == SC_PAUSE) ||
             (b == SC_BAT)  || (b == SC_ACK)    || (b == SC_ECHO)  ||
             (b == SC_RESEND) || (b == SC_ERR0) || (b == SC_ERR1);
   endfunction

endpackage

// File: rtl/ps2_scancode_decoder_kbd_event_fifo.sv
// Small synchronous FIFO of decoded key events; head is read combinationally and reads 0 when empty.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module kbd_event_fifo
   import ps2_scancode_decoder_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned PTR_W      = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_push,
   input  kbd_event_t i_data,
   input  logic       i_pop,
   output kbd_event_t o_head,
   output logic       o_full,
   output logic       o_empty
);

   localparam logic [PTR_W-1:0] PTR_ONE  = 1;
   localparam logic [PTR_W:0]   CNT_ONE  = 1;
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

   kbd_event_t       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_do_push;
   logic             w_do_pop;

   always_comb begin
      o_full    = (r_count == CNT_FULL);
      o_empty   = (r_count == '0);
      w_do_pop  = i_pop & ~o_empty;
      w_do_push = i_push & (~o_full | w_do_pop);
      o_head    = o_empty ? '0 : r_mem[r_rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + CNT_ONE;
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Pulls bytes from the PS/2 receiver, folds E0/F0 prefixes into key events and queues them.
// Define PAUSE_SEQ_EN to collapse the 8-byte Pause sequence (E1 ...) into one event {77, ext}.
module ps2_scancode_decoder
   import ps2_scancode_decoder_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned PTR_W      = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] i_rx_q,
   input  logic       i_rx_dsr,
   input  logic       i_rx_overflow,
   output logic       o_rx_rden,
   output logic [7:0] o_ev_code,
   output logic       o_ev_ext,
   output logic       o_ev_release,
   output logic       o_ev_valid,
   input  logic       i_ev_ready,
   output logic       o_ev_lost
);

`ifdef PAUSE_SEQ_EN
   localparam logic [7:0] SC_PAUSE_KEY   = 8'h77;
   localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;
   logic [2:0] r_skip_cnt;
`endif

   dec_state_t r_state;
   logic       r_rden;
   logic       r_ext;
   logic       r_rel;
   logic       r_lost;
   logic       w_push;
   kbd_event_t w_ev;
   kbd_event_t w_head;
   logic       w_full;
   logic       w_empty;
   logic       w_pop;

   assign w_pop = i_ev_ready & ~w_empty;

   always_comb begin
      w_push = 1'b0;
      // An overflow in the decode cycle still lets the byte through, but without its prefixes.
      w_ev = '{code: i_rx_q, ext: r_ext & ~i_rx_overflow, rel: r_rel & ~i_rx_overflow};
      if (r_state == StDecode) begin
`ifdef PAUSE_SEQ_EN
         if (r_skip_cnt != '0) begin
            if (r_skip_cnt == 3'd1 && !i_rx_overflow) begin
               w_push = 1'b1;
               w_ev   = '{code: SC_PAUSE_KEY, ext: 1'b1, rel: 1'b0};
            end
         end else begin
            w_push = ~is_control_byte(i_rx_q);
         end
`else
         w_push = ~is_control_byte(i_rx_q);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
         r_rden  <= 1'b0;
         r_ext   <= 1'b0;
         r_rel   <= 1'b0;
         r_lost  <= 1'b0;
`ifdef PAUSE_SEQ_EN
         r_skip_cnt <= '0;
`endif
      end else begin
         r_lost <= w_push & w_full & ~w_pop;
         unique case (r_state)
            StIdle: begin
               if (i_rx_dsr) begin
                  r_state <= StRead;
                  r_rden  <= 1'b1;
               end
            end
            StRead: begin
               r_state <= StDecode;
               r_rden  <= 1'b0;
            end
            StDecode: begin
               r_state <= StIdle;
`ifdef PAUSE_SEQ_EN
               if (r_skip_cnt != '0) begin
                  r_skip_cnt <= r_skip_cnt - 3'd1;
               end else
`endif
               if (i_rx_q == SC_EXT) begin
                  r_ext <= 1'b1;
               end else if (i_rx_q == SC_REL) begin
                  r_rel <= 1'b1;
               end else begin
                  r_ext <= 1'b0;
                  r_rel <= 1'b0;
`ifdef PAUSE_SEQ_EN
                  if (i_rx_q == SC_PAUSE) begin
                     r_skip_cnt <= PAUSE_SKIP_LEN;
                  end
`endif
               end
            end
            default: begin
               r_state <= StIdle;
               r_rden  <= 1'b0;
            end
         endcase
         // Watchdog abandons any half-received sequence; takes priority over decode updates.
         if (i_rx_overflow) begin
            r_ext <= 1'b0;
            r_rel <= 1'b0;
`ifdef PAUSE_SEQ_EN
            r_skip_cnt <= '0;
`endif
         end
      end
   end

   kbd_event_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .PTR_W      (PTR_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (w_ev),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign o_rx_rden    = r_rden;
   assign o_ev_code    = w_head.code;
   assign o_ev_ext     = w_head.ext;
   assign o_ev_release = w_head.rel;
   assign o_ev_valid   = ~w_empty;
   assign o_ev_lost    = r_lost;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: a receiver model feeds bytes, a reference decoder
// predicts events and drops, and a monitor compares the FIFO head whenever events are presented.
module tb_ps2_scancode_decoder;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_q;
   logic       rx_dsr;
   logic       rx_ovf;
   logic       rx_rden;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_rel;
   logic       ev_valid;
   logic       ev_ready;
   logic       ev_lost;

   always #5 clk = ~clk;

   ps2_scancode_decoder #(
      .FIFO_DEPTH (DEPTH),
      .PTR_W      (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_rx_q        (rx_q),
      .i_rx_dsr      (rx_dsr),
      .i_rx_overflow (rx_ovf),
      .o_rx_rden     (rx_rden),
      .o_ev_code     (ev_code),
      .o_ev_ext      (ev_ext),
      .o_ev_release  (ev_rel),
      .o_ev_valid    (ev_valid),
      .i_ev_ready    (ev_ready),
      .o_ev_lost     (ev_lost)
   );

   typedef struct {
      logic [7:0] code;
      bit         ext;
      bit         rel;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] byte_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   bit         active   = 1'b0;
   int         ready_mode = 0;   // 0 low, 1 high, 2 random
   int         ovf_rate   = 0;   // 0 never, else 1-in-N cycles
   bit         ovf_req    = 1'b0;
   bit         pend       = 1'b0;
   logic [7:0] pend_byte;
   bit         exp_lost   = 1'b0;
   int         lost_seen  = 0;
   bit         rden_prev  = 1'b0;
   bit         m_ext = 1'b0;
   bit         m_rel = 1'b0;
   int         m_skip = 0;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endfunction

   // Reference decoder: one received byte plus the overflow seen in its decode cycle.
   function automatic bit model_byte(input logic [7:0] b, input bit ovf, output ev_t e);
      bit has_ev = 1'b0;
      if (ovf) begin
         m_ext = 1'b0;
         m_rel = 1'b0;
      end
      e = '{b, m_ext, m_rel};
      if (m_skip > 0) begin
         if (ovf) m_skip = 0;
         else begin
            m_skip--;
            if (m_skip == 0) begin
               e = '{8'h77, 1'b1, 1'b0};
               has_ev = 1'b1;
            end
         end
      end else begin
         case (b)
            8'hE0: m_ext = 1'b1;
            8'hF0: m_rel = 1'b1;
            8'hE1: begin
               m_ext = 1'b0;
               m_rel = 1'b0;
`ifdef PAUSE_SEQ_EN
               m_skip = 7;
`endif
            end
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
               m_ext = 1'b0;
               m_rel = 1'b0;
            end
            default: begin
               has_ev = 1'b1;
               m_ext  = 1'b0;
               m_rel  = 1'b0;
            end
         endcase
      end
      if (ovf) begin
         m_ext  = 1'b0;
         m_rel  = 1'b0;
         m_skip = 0;
      end
      return has_ev;
   endfunction

   // Receiver model, reference model and monitor; inputs change on the falling edge.
   always @(negedge clk) begin
      ev_t e;
      if (active) begin
         case (ready_mode)
            0:       ev_ready = 1'b0;
            1:       ev_ready = 1'b1;
            default: ev_ready = ($urandom_range(0, 3) != 0);
         endcase
         rx_ovf  = ovf_req || (ovf_rate != 0 && $urandom_range(1, ovf_rate) == 1);
         ovf_req = 1'b0;

         if (ev_lost || exp_lost) check("ev_lost", ev_lost, exp_lost);
         if (ev_lost) lost_seen++;
         exp_lost = 1'b0;

         if (rx_rden) check("rx_rden_single_cycle", rden_prev, 0);
         rden_prev = rx_rden;

         if (ev_valid || exp_q.size() > 0) begin
            if (exp_q.size() == 0) check("ev_valid_spurious", ev_valid, 0);
            else if (!ev_valid) check("ev_valid_missing", ev_valid, 1);
            else begin
               check("ev_head", {ev_code, ev_ext, ev_rel},
                     {exp_q[0].code, exp_q[0].ext, exp_q[0].rel});
               if (ev_ready) void'(exp_q.pop_front());
            end
         end

         if (pend) begin
            pend = 1'b0;
            if (model_byte(pend_byte, rx_ovf, e)) begin
               if (exp_q.size() >= DEPTH) exp_lost = 1'b1;
               else exp_q.push_back(e);
            end
         end else if (rx_ovf) begin
            m_ext  = 1'b0;
            m_rel  = 1'b0;
            m_skip = 0;
         end

         if (rx_rden) begin
            if (byte_q.size() > 0) begin
               rx_q      = byte_q.pop_front();
               pend      = 1'b1;
               pend_byte = rx_q;
            end else begin
               check("rx_rden_without_dsr", rx_rden, 0);
            end
         end
         rx_dsr = (byte_q.size() > 0);
      end
   end

   task automatic send(input logic [7:0] b);
      byte_q.push_back(b);
   endtask

   task automatic settle(input int extra);
      int t = 0;
      while ((byte_q.size() != 0 || pend || rx_rden || rx_dsr) && t < 5000) begin
         @(posedge clk);
         t++;
      end
      if (t >= 5000) check("settle_timeout", byte_q.size(), 0);
      repeat (extra + 3) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int t = 0;
      ready_mode = 1;
      while (exp_q.size() != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      if (t >= 200) check("drain_timeout", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      active = 1'b0;
      reset  = 1'b1;
      rx_dsr = 1'b0;
      rx_ovf = 1'b0;
      ev_ready = 1'b0;
      byte_q.delete();
      exp_q.delete();
      pend = 1'b0;
      exp_lost = 1'b0;
      rden_prev = 1'b0;
      m_ext = 1'b0;
      m_rel = 1'b0;
      m_skip = 0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int l0;
      logic [7:0] status_tbl [6];
      status_tbl = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
      rx_q = 8'h00;
      do_reset();
      check("reset_rden",  rx_rden,  0);
      check("reset_valid", ev_valid, 0);
      check("reset_head",  {ev_code, ev_ext, ev_rel}, 0);
      check("reset_lost",  ev_lost,  0);
      reset  = 1'b0;
      active = 1'b1;
      @(posedge clk);
      #1;

      // Latency: byte queued in cycle k, event visible in k+3.
      ready_mode = 0;
      send(8'h1C);
      @(posedge clk); #1;
      check("lat_rden_n1", rx_rden, 1);
      check("lat_valid_n1", ev_valid, 0);
      @(posedge clk); #1;
      check("lat_rden_n2", rx_rden, 0);
      check("lat_valid_n2", ev_valid, 0);
      @(posedge clk); #1;
      check("lat_valid_n3", ev_valid, 1);
      drain();

      send(8'hF0); send(8'h1C);
      settle(2);
      drain();

      // Single entry: one pop empties the FIFO.
      send(8'hE0); send(8'hF0); send(8'h75);
      settle(2);
      ready_mode = 1;
      @(posedge clk); #1;
      check("single_entry_popped", ev_valid, 0);

      // Overfill with consumer stalled.
      ready_mode = 0;
      l0 = lost_seen;
      send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B); send(8'h34);
      settle(3);
      check("lost_pulse_count", lost_seen - l0, 1);
      drain();
      check("empty_after_drain", ev_valid, 0);

      send(8'hE0); send(8'hAA); send(8'h1C);
      settle(2);
      send(8'hE0);
      settle(2);
      ovf_req = 1'b1;
      @(posedge clk); #1;
      send(8'h74);
      settle(2);
      drain();
      ready_mode = 0;
      send(8'hFA);
      settle(4);
      check("status_no_event", ev_valid, 0);

      ready_mode = 1;
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      settle(2);
      drain();

      // Reset mid-sequence drops the pending prefix and buffered events.
      ready_mode = 0;
      send(8'h2B); send(8'hE0);
      settle(2);
      do_reset();
      check("midreset_valid", ev_valid, 0);
      reset  = 1'b0;
      active = 1'b1;
      send(8'h1C);
      settle(2);
      drain();

      // Randomised traffic with random back-pressure and watchdog pulses.
      ready_mode = 2;
      ovf_rate   = 40;
      for (int i = 0; i < 300; i++) begin
         int r;
         r = $urandom_range(0, 15);
         if (r < 2) send(8'hE0);
         else if (r < 4) send(8'hF0);
         else if (r == 4) send(status_tbl[$urandom_range(0, 5)]);
         else if (r == 5) send(8'hE1);
         else send(8'($urandom_range(1, 254)));
      end
      settle(4);
      ovf_rate = 0;
      drain();
      check("final_valid", ev_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 byte receiver; pulls received bytes through its dsr/rden handshake.
- Folds Set-2 prefix bytes (E0 extended, F0 release) into single key events.
- Discards protocol/status bytes.
- Buffers decoded events in a small FIFO for the keyboard-matrix mapper, which consumes them with a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4: event FIFO entries; power of two, minimum 2.
- PTR_W, 2: log2(FIFO_DEPTH); pointer width.

Ports:
- clk  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- rx_q  input  8  received byte from receiver; valid the cycle after rx_rden
- rx_dsr  input  1  receiver has a byte pending
- rx_overflow  input  1  receiver watchdog pulse (stuck frame)
- rx_rden  output  1  one-cycle read strobe to receiver, registered
- ev_code  output  8  head event scancode (final byte of sequence)
- ev_ext  output  1  head event carried E0 prefix
- ev_release  output  1  head event carried F0 prefix (key up)
- ev_valid  output  1  FIFO non-empty
- ev_ready  input  1  consumer pops head when ev_valid & ev_ready
- ev_lost  output  1  one-cycle pulse: event dropped, FIFO full

Behaviour:
- Reset:
  - state=IDLE; rx_rden=0; ev_lost=0.
  - Prefix flags ext_f=0, rel_f=0.
  - FIFO empty, so ev_valid=0; ev_code/ev_ext/ev_release read 0.
- FSM IDLE:
  - rx_dsr=1 → READ; rx_rden=1 during READ (exactly one cycle).
- FSM READ:
  - unconditionally → DECODE; rx_rden returns to 0.
- FSM DECODE:
  - Samples rx_q, then → IDLE.
  - rx_dsr is never sampled in READ or DECODE, which avoids a double read.
- Decode rules in DECODE, first match wins:
  - E0: set ext_f; no event.
  - F0: set rel_f; no event.
  - AA, FA, EE, FE, 00, FF: clear both flags; no event.
  - Any other byte: push {byte, ext_f, rel_f}; clear both flags.
- Latency:
  - rx_dsr sampled high in cycle N → rx_rden high in N+1 → decode in N+2.
  - If the FIFO was empty, ev_valid is high in N+3.
- FIFO:
  - Push and pop on the same cycle are both honoured, including when full (push accepted because the pop frees a slot).
  - Push when full without a pop: event dropped, ev_lost pulses for 1 cycle, FIFO contents unchanged.
  - Pointers wrap modulo FIFO_DEPTH; the count register is PTR_W+1 bits.
  - ev_ready while empty: ignored.
- rx_overflow=1 in any cycle clears ext_f and rel_f (a half-received sequence is abandoned). The FSM is not disturbed; a byte being fetched still decodes, with flags cleared.
- Flags persist across arbitrary idle time between prefix and code byte. There is no timeout; recovery relies on rx_overflow.
- Reset mid-sequence discards flags and FIFO contents. rx_rden is deasserted the following cycle.

Optional Feature:
- PAUSE_SEQ_EN defined:
  - In DECODE, byte E1 enters sub-state SKIP with a 3-bit counter of 7.
  - The next 7 bytes are fetched normally but produce no events.
  - After the 7th, a single event {77, ext=1, release=0} is pushed.
  - rx_overflow during SKIP aborts to IDLE without an event.
- PAUSE_SEQ_EN undefined:
  - E1 is treated as a status byte: discarded, flags cleared.
  - The following bytes decode normally.

Decomposition:
- Shared keyboard package holds:
  - Prefix/status byte constants (SC_EXT=E0, SC_REL=F0, SC_PAUSE=E1, SC_BAT=AA, SC_ACK=FA, …).
  - FSM state encoding.
  - The 10-bit event record type {code, ext, release}.
- One sub-module: kbd_event_fifo, a parameterised synchronous FIFO with push/pop/full/empty. The decoder FSM stays in the top module.

Test Plan:
- Byte 1C presented on rx_dsr → rx_rden exactly 1 cycle; ev_valid 3 cycles later with ev_code=1C, ext=0, release=0.
- Bytes F0,1C → one event: ev_code=1C, release=1.
- Bytes E0,F0,75 → one event: ev_code=75, ext=1, release=1; FIFO holds exactly 1 entry.
- With ev_ready=0:
  - Send 1C,1B,23,2B,34 → 4 events buffered; on 5th byte ev_lost pulses once.
  - Then ev_ready=1 → pops 1C,1B,23,2B in order, then ev_valid=0.
- Status bytes:
  - E0,AA,1C → event 1C with ext=0.
  - E0, rx_overflow pulse, 74 → event 74 with ext=0.
  - FA alone → no event.
- Pause sequence E1,14,77,E1,F0,14,F0,77:
  - With PAUSE_SEQ_EN: single event 77, ext=1, release=0.
  - Without: events 14, 77, 14(release=1), 77(release=1).
